mul_iter_unit: RTL

- Parametrised, multi-cycle shift-add multiply/accumulate unit. Replaces the single-cycle `*` path for MUL/MLA/MLS in the ALU and adds a UMULL-style double-width unsigned product.
- Sits beside the ALU in the Execute stage of the ARM pipeline.
- Uses a valid/ready handshake on both sides so the hazard unit can stall on `in_ready`/`out_valid`.
- A flush input lets a branch kill an in-flight multiply.

---
 rtl/mul_iter_unit_if.sv | 26 ++
 rtl/mul_iter_unit.sv | 84 ++++++++
 2 files changed

// File: rtl/mul_iter_unit_if.sv
// mul_iter_unit_if: request/response bundle for the iterative multiplier.
// Request side:  in_valid, in_ready, op, src_a, src_b, src_c, flush.
// Response side: out_valid, out_ready, result_lo, result_hi, flags_nz.
// master drives requests and consumes results; slave is the multiplier.
interface mul_iter_unit_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] src_c;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic [1:0]       flags_nz;
  modport master (
    output in_valid, op, src_a, src_b, src_c, flush, out_ready,
    input  in_ready, out_valid, result_lo, result_hi, flags_nz
  );
  modport slave (
    input  in_valid, op, src_a, src_b, src_c, flush, out_ready,
    output in_ready, out_valid, result_lo, result_hi, flags_nz
  );
endinterface

// File: rtl/mul_iter_unit.sv
// mul_iter_unit: multi-cycle shift-add MUL/MLA/MLS/UMULL unit, K multiplier bits per cycle.
// Ports: clk (rising edge), reset (async, active low), bus (mul_iter_unit_if.slave):
//   op 00 MUL, 01 MLA, 10 MLS, 11 UMULL; result_hi is nonzero only for UMULL;
//   flags_nz = {N, Z} of the full result.
module mul_iter_unit #(
  parameter int WIDTH = 32,
  parameter int K     = 1
) (
  input logic          clk,
  input logic          reset,
  mul_iter_unit_if.slave bus
);
  localparam int N  = WIDTH / K;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, RUN, ACC, DONE} state_t;
  state_t             state, state_nx;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   mplier, c_q, acc_lo, acc_hi;
  logic [2*WIDTH-1:0] mcand, prod;
  logic [CW-1:0]      count;
  logic               accept;
  generate
    if (WIDTH % K != 0 || !(K == 1 || K == 2 || K == 4)) begin : g_bad_cfg
      initial $error("mul_iter_unit: WIDTH must be a multiple of K and K must be 1, 2 or 4");
    end
  endgenerate
  assign bus.in_ready  = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign accept        = state == IDLE && bus.in_valid && !bus.flush;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  always_comb begin
    state_nx = state;
    if (bus.flush) state_nx = IDLE;
    else
      case (state)
        IDLE:    state_nx = bus.in_valid ? RUN : IDLE;
        RUN:     state_nx = count == CW'(1) ? ACC : RUN;
        ACC:     state_nx = DONE;
        default: state_nx = bus.out_ready ? IDLE : DONE;
      endcase
  end
  // Final combine of the raw product with the accumulator operand.
  always_comb begin
    acc_hi = op_q == 2'b11 ? prod[2*WIDTH-1:WIDTH] : '0;
    acc_lo = op_q == 2'b01 ? c_q + prod[WIDTH-1:0]
           : op_q == 2'b10 ? c_q - prod[WIDTH-1:0]
           : prod[WIDTH-1:0];
  end
  // The multiplicand is kept pre-shifted, so each step adds the partial
  // product at its running bit position without a separate shift amount.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      op_q          <= '0;
      mplier        <= '0;
      c_q           <= '0;
      mcand         <= '0;
      prod          <= '0;
      count         <= '0;
      bus.result_lo <= '0;
      bus.result_hi <= '0;
      bus.flags_nz  <= '0;
    end else begin
      if (accept) begin
        op_q   <= bus.op;
        mplier <= bus.src_b;
        c_q    <= bus.src_c;
        mcand  <= {{WIDTH{1'b0}}, bus.src_a};
        prod   <= '0;
        count  <= CW'(N);
      end else if (state == RUN) begin
        prod   <= prod + mcand * {{(2*WIDTH-K){1'b0}}, mplier[K-1:0]};
        mplier <= mplier >> K;
        mcand  <= mcand << K;
        count  <= count - CW'(1);
      end
      if (state == ACC && !bus.flush) begin
        bus.result_lo <= acc_lo;
        bus.result_hi <= acc_hi;
        bus.flags_nz  <= {op_q == 2'b11 ? acc_hi[WIDTH-1] : acc_lo[WIDTH-1], ~|{acc_hi, acc_lo}};
      end
    end
endmodule
